// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding, parameter legality limits and the
// counter-width helper used by seq_divider.
package seq_div_pkg;

    // FSM states of the divider
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Legal parameter ranges (VW must also not exceed DW)
    localparam int DW_MIN = 4;
    localparam int DW_MAX = 32;
    localparam int VW_MIN = 2;

    // Iteration counter width for the default dividend width
    localparam int DW_DEFAULT    = 16;
    localparam int CNT_W_DEFAULT = $clog2(DW_DEFAULT + 1);

    // Iteration counter width for an arbitrary dividend width
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one combinational restoring-division iteration.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, producing the new partial remainder and quotient bit.
module seq_div_step #(
    parameter int VW = 8
) (
    input  logic [VW:0]   r_cur,
    input  logic          x_msb,
    input  logic [VW-1:0] y,
    output logic [VW:0]   r_next,
    output logic          q_bit
);

    logic [VW:0] t;

    // Trial subtraction; a set top bit of r_cur would mean T overflowed, so it always fits
    always_comb begin
        t = {r_cur[VW-1:0], x_msb};
        if (r_cur[VW] || (t >= {1'b0, y})) begin
            r_next = t - {1'b0, y};
            q_bit  = 1'b1;
        end else begin
            r_next = t;
            q_bit  = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: DW-by-VW multi-cycle restoring divider, one quotient bit per clock.
// start/done handshake: start is sampled only in IDLE (accept edge); busy is
// high from the accept edge to the done edge; done pulses for one cycle with
// quotient/remainder/dz valid, and the results hold until the next done.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (two's complement operands,
// adds the FIX state for sign correction).
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          dz,
    output logic [1:0]    state_dbg
);

    localparam int            CW       = cnt_width(DW);
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

    if (DW < DW_MIN || DW > DW_MAX || VW < VW_MIN || VW > DW) begin : g_bad_params
        $error("seq_divider: illegal DW/VW combination");
    end

    state_t        state_q, state_d;
    logic [VW:0]   r_q;
    logic [DW-1:0] x_q;
    logic [VW-1:0] y_q;
    logic [CW-1:0] cnt_q;
    logic [VW:0]   r_step;
    logic          q_bit;
    logic          accept, iter, commit;
    logic          div_zero;
    logic [DW-1:0] dvd_mag;
    logic [VW-1:0] dvs_mag;

    assign div_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic sign_q_q, sign_r_q;
    logic do_fix;
    assign dvd_mag = dividend[DW-1] ? -dividend : dividend;
    assign dvs_mag = divisor[VW-1]  ? -divisor  : divisor;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
`endif

    seq_div_step #(.VW(VW)) u_step (
        .r_cur  (r_q),
        .x_msb  (x_q[DW-1]),
        .y      (y_q),
        .r_next (r_step),
        .q_bit  (q_bit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = div_zero ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (cnt_q == LAST_CNT) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    state_d = ST_FIX;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        accept    = (state_q == ST_IDLE) && start;
        iter      = (state_q == ST_RUN);
        commit    = (state_q == ST_DONE);
        state_dbg = state_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        do_fix    = (state_q == ST_FIX);
`endif
    end

    // Working registers: operand load, shift/subtract iterations, sign fix-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
`endif
        end else if (accept) begin
            r_q   <= '0;
            y_q   <= dvs_mag;
            cnt_q <= '0;
            // Divide-by-zero result is produced directly from the loaded X
            x_q   <= div_zero ? '1 : dvd_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sign_q_q <= dividend[DW-1] ^ divisor[VW-1];
            sign_r_q <= dividend[DW-1];
`endif
        end else if (iter) begin
            r_q   <= r_step;
            x_q   <= {x_q[DW-2:0], q_bit};
            cnt_q <= cnt_q + 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
        end else if (do_fix) begin
            // Truncation toward zero: quotient takes the XOR sign, remainder the dividend sign
            x_q <= sign_q_q ? -x_q : x_q;
            r_q <= {1'b0, (sign_r_q ? -r_q[VW-1:0] : r_q[VW-1:0])};
`endif
        end
    end

    // Handshake and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dz        <= 1'b0;
        end else begin
            done <= commit;
            if (accept) begin
                busy <= 1'b1;
                dz   <= div_zero;
            end
            if (commit) begin
                busy      <= 1'b0;
                quotient  <= x_q;
                remainder <= r_q[VW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed, table-driven bench for seq_divider (DW=16, VW=8),
// plus hand-written sequences for ignored start, back-to-back and reset abort.
module tb_seq_divider;

    localparam int DW = 16;
    localparam int VW = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT = DW + 2;
`else
    localparam int LAT = DW + 1;
`endif
    localparam int TIMEOUT = 100;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          dz;
    logic [1:0]    state_dbg;

    int total = 0;
    int bad   = 0;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dz        (dz),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
        int            lat;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Driver: start one operation from IDLE and wait (bounded) for done.
    // glitch_at > 0 pulses start with other operands on that cycle of the run.
    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int glitch_at,
                          output logic [DW-1:0] q, output logic [VW-1:0] r, output logic z,
                          output int lat, output int bcnt);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 16'hA5C3;
        divisor  = 8'h3C;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k == glitch_at) begin
                start    = 1'b1;
                dividend = 16'd50;
                divisor  = 8'd5;
            end
            @(posedge clk); #1;
            if (k == glitch_at) start = 1'b0;
            check("busy_done_overlap", 32'(busy & done), 32'd0);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
        end
        q = quotient;
        r = remainder;
        z = dz;
    endtask

    initial begin
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
        int            lat, bcnt;
        int            tdone[3];
        int            nd;

`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs[0] = '{16'hFF9C, 8'd7,   16'hFFF2, 8'hFE,  1'b0, LAT}; // -100/7
        vecs[1] = '{16'd100,  8'hF9,  16'hFFF2, 8'd2,   1'b0, LAT}; // 100/-7
        vecs[2] = '{16'h8000, 8'hFF,  16'h8000, 8'd0,   1'b0, LAT}; // -32768/-1
        vecs[3] = '{16'd1234, 8'd0,   16'hFFFF, 8'd0,   1'b1, 1};   // divide by zero
        vecs[4] = '{16'd10,   8'd3,   16'd3,    8'd1,   1'b0, LAT}; // dz clears
        vecs[5] = '{16'hFFF9, 8'hFE,  16'd3,    8'hFF,  1'b0, LAT}; // -7/-2
        vecs[6] = '{16'd0,    8'd5,   16'd0,    8'd0,   1'b0, LAT};
        vecs[7] = '{16'd12345, 8'd100, 16'd123, 8'd45,  1'b0, LAT};
`else
        vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,  1'b0, LAT};
        vecs[1] = '{16'd65535, 8'd255, 16'd257,   8'd0,  1'b0, LAT};
        vecs[2] = '{16'd5,     8'd200, 16'd0,     8'd5,  1'b0, LAT};
        vecs[3] = '{16'd1234,  8'd0,   16'hFFFF,  8'd0,  1'b1, 1};   // divide by zero
        vecs[4] = '{16'd10,    8'd3,   16'd3,     8'd1,  1'b0, LAT}; // dz clears
        vecs[5] = '{16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0, LAT};
        vecs[6] = '{16'd40000, 8'd200, 16'd200,   8'd0,  1'b0, LAT};
        vecs[7] = '{16'd12345, 8'd100, 16'd123,   8'd45, 1'b0, LAT};
`endif

        // Reset
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_quotient",  32'(quotient),  32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_dz",        32'(dz),        32'd0);
        check("rst_state",     32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, q, r, z, lat, bcnt);
            check($sformatf("v%0d_quotient", i),  32'(q),    32'(vecs[i].q));
            check($sformatf("v%0d_remainder", i), 32'(r),    32'(vecs[i].r));
            check($sformatf("v%0d_dz", i),        32'(z),    32'(vecs[i].z));
            check($sformatf("v%0d_latency", i),   32'(lat),  32'(vecs[i].lat));
            check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
        end

        // start pulsed mid-run with 50/5 must be ignored
        run_op(16'd1000, 8'd7, 5, q, r, z, lat, bcnt);
        check("ignore_quotient",  32'(q),   32'd142);
        check("ignore_remainder", 32'(r),   32'd6);
        check("ignore_latency",   32'(lat), 32'(LAT));

        // start held high: three back-to-back operations
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        nd = 0;
        for (int k = 0; k < 3 * TIMEOUT && nd < 3; k++) begin
            @(posedge clk); #1;
            check("b2b_overlap", 32'(busy & done), 32'd0);
            if (done) begin
                tdone[nd] = k;
                check($sformatf("b2b%0d_quotient", nd),  32'(quotient),  32'd142);
                check($sformatf("b2b%0d_remainder", nd), 32'(remainder), 32'd6);
                nd++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(nd), 32'd3);
        if (nd == 3) begin
            check("b2b_first_done", 32'(tdone[0]), 32'(LAT));
            check("b2b_period_1",   32'(tdone[1] - tdone[0]), 32'(LAT + 1));
            check("b2b_period_2",   32'(tdone[2] - tdone[1]), 32'(LAT + 1));
        end
        @(posedge clk); #1;
        check("b2b_idle_after", 32'(busy), 32'd0);

        // Reset asserted on cycle 8 of RUN aborts the operation
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_quotient",  32'(quotient),  32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_done",      32'(done),      32'd0);
        check("abort_dz",        32'(dz),        32'd0);
        check("abort_state",     32'(state_dbg), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < LAT + 5; k++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);

        run_op(16'd100, 8'd9, 0, q, r, z, lat, bcnt);
        check("post_rst_quotient",  32'(q),   32'd11);
        check("post_rst_remainder", 32'(r),   32'd1);
        check("post_rst_dz",        32'(z),   32'd0);
        check("post_rst_latency",   32'(lat), 32'(LAT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
